// File: rtl/sprite_render_pkg.sv
// Shared constants and types for the sprite renderer.
// Imported by the interface, the blink timer and the sprite_render top.
package sprite_pkg;

   localparam int LATENCY             = 4;
   localparam int DEF_SPRITE_W        = 32;
   localparam int DEF_SPRITE_H        = 32;
   localparam int DEF_IDX_W           = 4;
   localparam int DEF_TRANSPARENT_IDX = 0;

   typedef logic [23:0] rgb_t;

   // Field width for a select of n items; a single item still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sprite_render_if.sv
// Video-timing, sprite-control and ROM signals of sprite_render.
// The slave modport is the renderer; the master side is timing gen, ROMs and compositor.
interface sprite_render_if
   import sprite_pkg::*;
#(
   parameter int HC_W    = 11,
   parameter int VC_W    = 10,
   parameter int FRAME_W = 2,
   parameter int AW      = 12,
   parameter int IDX_W   = DEF_IDX_W
);

   logic [HC_W-1:0]    hcount;
   logic [VC_W-1:0]    vcount;
   logic               blank;
   logic               hsync;
   logic               vsync;
   logic [HC_W-1:0]    x;
   logic [VC_W-1:0]    y;
   logic [FRAME_W-1:0] frame;
   logic               enable;
   logic               blink;
   logic               mirror_h;

   logic [AW-1:0]      map_addr;
   logic [IDX_W-1:0]   map_data;
   logic [IDX_W-1:0]   pal_addr;
   rgb_t               pal_data;

   rgb_t               pixel;
   logic               pixel_valid;
   logic               hsync_out;
   logic               vsync_out;
   logic               blank_out;

   modport slave (
      input  hcount, vcount, blank, hsync, vsync,
      input  x, y, frame, enable, blink, mirror_h,
      output map_addr,
      input  map_data,
      output pal_addr,
      input  pal_data,
      output pixel, pixel_valid, hsync_out, vsync_out, blank_out
   );

   modport master (
      output hcount, vcount, blank, hsync, vsync,
      output x, y, frame, enable, blink, mirror_h,
      input  map_addr,
      output map_data,
      input  pal_addr,
      output pal_data,
      input  pixel, pixel_valid, hsync_out, vsync_out, blank_out
   );

endinterface

// File: rtl/sprite_render_blink_timer.sv
// Blink phase generator: toggles visibility every BLINK_FRAMES vsync falling edges.
// visible is forced high while blink is low so disabling blink shows the sprite at once.
module sprite_blink_timer
   import sprite_pkg::*;
#(
   parameter int BLINK_FRAMES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic vsync,
   input  logic blink,
   output logic visible
);

   localparam int CNT_W = clog2_min1(BLINK_FRAMES);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             vis_q, vis_d;
   logic             vsync_q;
   logic             vsync_fall;

   assign vsync_fall = vsync_q & ~vsync;

   always_comb begin
      cnt_d = cnt_q;
      vis_d = vis_q;
      if (!blink) begin
         cnt_d = '0;
         vis_d = 1'b1;
      end else if (vsync_fall) begin
         if (cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
            cnt_d = '0;
            vis_d = ~vis_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // vsync history tracks the input through reset so an edge spanning reset is not counted.
   always_ff @(posedge clk) begin
      vsync_q <= vsync;
      if (reset) begin
         cnt_q <= '0;
         vis_q <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         vis_q <= vis_d;
      end
   end

   assign visible = vis_q | ~blink;

endmodule

// File: rtl/sprite_render.sv
// Sprite pixel generator: hit test, colour-map/palette lookup, 4-clock aligned outputs.
// Optional macro SPRITE_RENDER_MIRROR_EN enables horizontal mirroring via mirror_h.
module sprite_render
   import sprite_pkg::*;
#(
   parameter int SPRITE_W        = DEF_SPRITE_W,
   parameter int SPRITE_H        = DEF_SPRITE_H,
   parameter int FRAMES          = 4,
   parameter int IDX_W           = DEF_IDX_W,
   parameter int HC_W            = 11,
   parameter int VC_W            = 10,
   parameter int TRANSPARENT_IDX = DEF_TRANSPARENT_IDX,
   parameter int BLINK_FRAMES    = 16
) (
   input  logic           clk,
   input  logic           reset,
   sprite_render_if.slave bus
);

   localparam int COL_W      = $clog2(SPRITE_W);
   localparam int ROW_W      = $clog2(SPRITE_H);
   localparam int FRAME_BITS = $clog2(FRAMES);
   localparam int AW         = FRAME_BITS + ROW_W + COL_W;

   logic visible;

   sprite_blink_timer #(
      .BLINK_FRAMES(BLINK_FRAMES)
   ) u_blink (
      .clk    (clk),
      .reset  (reset),
      .vsync  (bus.vsync),
      .blink  (bus.blink),
      .visible(visible)
   );

   // Stage 0: hit test and colour-map address
   logic [HC_W:0]    x_end;
   logic [VC_W:0]    y_end;
   logic             in_x, in_y;
   logic [HC_W-1:0]  col_diff;
   logic [VC_W-1:0]  row_diff;
   logic [COL_W-1:0] col, col_m;
   logic [ROW_W-1:0] row;
   logic [AW-1:0]    addr_hit, addr_miss;
   logic             hit_d;
   logic [AW-1:0]    map_addr_d;

   // One extra bit on the end coordinates so a sprite past the raster edge clips instead of wrapping.
   assign x_end    = {1'b0, bus.x} + (HC_W+1)'(SPRITE_W);
   assign y_end    = {1'b0, bus.y} + (VC_W+1)'(SPRITE_H);
   assign in_x     = (bus.hcount >= bus.x) && ({1'b0, bus.hcount} < x_end);
   assign in_y     = (bus.vcount >= bus.y) && ({1'b0, bus.vcount} < y_end);
   assign col_diff = bus.hcount - bus.x;
   assign row_diff = bus.vcount - bus.y;
   assign col      = col_diff[COL_W-1:0];
   assign row      = row_diff[ROW_W-1:0];

   logic unused_diff_bits;
   assign unused_diff_bits = ^{col_diff[HC_W-1:COL_W], row_diff[VC_W-1:ROW_W]};

`ifdef SPRITE_RENDER_MIRROR_EN
   // SPRITE_W is a power of two, so SPRITE_W-1-col is the bitwise complement.
   assign col_m = bus.mirror_h ? ~col : col;
`else
   logic unused_mirror;
   assign unused_mirror = bus.mirror_h;
   assign col_m         = col;
`endif

   generate
      if (FRAME_BITS > 0) begin : g_frames
         assign addr_hit  = {bus.frame, row, col_m};
         assign addr_miss = {bus.frame, {(ROW_W + COL_W){1'b0}}};
      end else begin : g_single
         logic unused_frame;
         assign unused_frame = ^bus.frame;
         assign addr_hit     = {row, col_m};
         assign addr_miss    = '0;
      end
   endgenerate

   always_comb begin
      hit_d      = bus.enable & ~bus.blank & visible & in_x & in_y;
      map_addr_d = hit_d ? addr_hit : addr_miss;
   end

   logic          hit0_q, hit1_q;
   logic [AW-1:0] map_addr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hit0_q     <= 1'b0;
         map_addr_q <= '0;
      end else begin
         hit0_q     <= hit_d;
         map_addr_q <= map_addr_d;
      end
   end

   // Stage 1 -> 2: map_data arrives; opacity decided against the transparency key
   logic opaque_d, opaque_q;

   assign opaque_d = hit1_q & (bus.map_data != IDX_W'(TRANSPARENT_IDX));

   always_ff @(posedge clk) begin
      if (reset) begin
         hit1_q   <= 1'b0;
         opaque_q <= 1'b0;
      end else begin
         hit1_q   <= hit0_q;
         opaque_q <= opaque_d;
      end
   end

   // Stage 3: pal_data arrives; masked colour out
   rgb_t pixel_d, pixel_q;
   logic valid_q;

   assign pixel_d = opaque_q ? bus.pal_data : '0;

   always_ff @(posedge clk) begin
      if (reset) begin
         pixel_q <= '0;
         valid_q <= 1'b0;
      end else begin
         pixel_q <= pixel_d;
         valid_q <= opaque_q;
      end
   end

   // Sync/blank delay line matched to the pixel path
   logic [LATENCY-1:0] hs_q, vs_q, bl_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         hs_q <= '1;
         vs_q <= '1;
         bl_q <= '1;
      end else begin
         hs_q <= {hs_q[LATENCY-2:0], bus.hsync};
         vs_q <= {vs_q[LATENCY-2:0], bus.vsync};
         bl_q <= {bl_q[LATENCY-2:0], bus.blank};
      end
   end

   assign bus.map_addr    = map_addr_q;
   assign bus.pal_addr    = bus.map_data;
   assign bus.pixel       = pixel_q;
   assign bus.pixel_valid = valid_q;
   assign bus.hsync_out   = hs_q[LATENCY-1];
   assign bus.vsync_out   = vs_q[LATENCY-1];
   assign bus.blank_out   = bl_q[LATENCY-1];

endmodule
